// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the unified instruction/data memory between the CPU datapath and the debug loader.
// Default is round-robin on ties; defining MEM_ARB_DBG_PRIORITY_EN makes debug win every tie.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_stall,
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    output logic          o_dbg_ack,
    output logic [DW-1:0] o_dbg_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
    typedef enum logic {SRC_CPU, SRC_DBG} src_t;

    // The ACCESS cycle covers one cycle of latency, WAIT covers the rest.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    src_t       grant, grant_nxt;
    logic [3:0] lat_cnt, lat_cnt_nxt;
    logic       mem_we_q;
    logic       take_grant;
    logic       capture;
    logic       dbg_wins_tie;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt   = state;
        grant_nxt   = grant;
        lat_cnt_nxt = lat_cnt;
        take_grant  = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cpu_req || i_dbg_req) begin
                    take_grant = 1'b1;
                    state_nxt  = ST_ACCESS;
                    if (i_cpu_req && i_dbg_req)
                        grant_nxt = dbg_wins_tie ? SRC_DBG : SRC_CPU;
                    else
                        grant_nxt = i_cpu_req ? SRC_CPU : SRC_DBG;
                end
            end
            ST_ACCESS: begin
                if (MEM_LAT == 1) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    lat_cnt_nxt = LAT_LOAD;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state       <= ST_IDLE;
            grant       <= SRC_CPU;
            lat_cnt     <= 4'd0;
            mem_we_q    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_cpu_rdata <= '0;
            o_dbg_rdata <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            if (take_grant) begin
                grant       <= grant_nxt;
                mem_we_q    <= (grant_nxt == SRC_CPU) ? i_cpu_we    : i_dbg_we;
                o_mem_addr  <= (grant_nxt == SRC_CPU) ? i_cpu_addr  : i_dbg_addr;
                o_mem_wdata <= (grant_nxt == SRC_CPU) ? i_cpu_wdata : i_dbg_wdata;
            end
            // Writes capture too; the requester ignores read data on a write ack.
            if (capture) begin
                if (grant == SRC_CPU) o_cpu_rdata <= i_mem_rdata;
                else                  o_dbg_rdata <= i_mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_DBG_PRIORITY_EN
    assign dbg_wins_tie = 1'b1;
`else
    src_t last_grant;

    // Pointer starts at DBG so the CPU wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset)         last_grant <= SRC_DBG;
        else if (take_grant) last_grant <= grant_nxt;
    end

    assign dbg_wins_tie = (last_grant == SRC_CPU);
`endif

    assign o_mem_en    = (state == ST_ACCESS);
    assign o_mem_we    = o_mem_en && mem_we_q;
    assign o_cpu_ack   = (state == ST_RESP) && (grant == SRC_CPU);
    assign o_dbg_ack   = (state == ST_RESP) && (grant == SRC_DBG);
    assign o_cpu_stall = i_cpu_req && !o_cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus against a transaction-level model of mem_arbiter,
// plus MEM_LAT=1/15 latency sweeps on two extra instances.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int CPU = 0;
    localparam int DBG = 1;
    localparam int M_QUIET = 0;
    localparam int M_RANDOM = 1;
    localparam int M_FLOOD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req      [2];
    logic        rq_we    [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic        ack_o    [2];
    logic [31:0] rdata_o  [2];
    logic        cpu_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(req[CPU]), .i_cpu_we(rq_we[CPU]), .i_cpu_addr(rq_addr[CPU]), .i_cpu_wdata(rq_wdata[CPU]),
        .o_cpu_ack(ack_o[CPU]), .o_cpu_rdata(rdata_o[CPU]), .o_cpu_stall(cpu_stall),
        .i_dbg_req(req[DBG]), .i_dbg_we(rq_we[DBG]), .i_dbg_addr(rq_addr[DBG]), .i_dbg_wdata(rq_wdata[DBG]),
        .o_dbg_ack(ack_o[DBG]), .o_dbg_rdata(rdata_o[DBG]),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Latency sweep instances: index 0 has MEM_LAT=1, index 1 has MEM_LAT=15.
    logic        sw_req [2];
    logic [31:0] sw_addr, sw_mem_rdata;
    logic        sw_ack [2], sw_stall [2], sw_en [2], sw_we [2], sw_dbg_ack [2];
    logic [31:0] sw_rdata [2], sw_dbg_rdata [2], sw_maddr [2], sw_mwdata [2];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(sw_req[0]), .i_cpu_we(1'b0), .i_cpu_addr(sw_addr), .i_cpu_wdata(32'h0),
        .o_cpu_ack(sw_ack[0]), .o_cpu_rdata(sw_rdata[0]), .o_cpu_stall(sw_stall[0]),
        .i_dbg_req(1'b0), .i_dbg_we(1'b0), .i_dbg_addr(32'h0), .i_dbg_wdata(32'h0),
        .o_dbg_ack(sw_dbg_ack[0]), .o_dbg_rdata(sw_dbg_rdata[0]),
        .o_mem_en(sw_en[0]), .o_mem_we(sw_we[0]), .o_mem_addr(sw_maddr[0]), .o_mem_wdata(sw_mwdata[0]),
        .i_mem_rdata(sw_mem_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(15)) u_lat15 (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(sw_req[1]), .i_cpu_we(1'b0), .i_cpu_addr(sw_addr), .i_cpu_wdata(32'h0),
        .o_cpu_ack(sw_ack[1]), .o_cpu_rdata(sw_rdata[1]), .o_cpu_stall(sw_stall[1]),
        .i_dbg_req(1'b0), .i_dbg_we(1'b0), .i_dbg_addr(32'h0), .i_dbg_wdata(32'h0),
        .o_dbg_ack(sw_dbg_ack[1]), .o_dbg_rdata(sw_dbg_rdata[1]),
        .o_mem_en(sw_en[1]), .o_mem_we(sw_we[1]), .o_mem_addr(sw_maddr[1]), .o_mem_wdata(sw_mwdata[1]),
        .i_mem_rdata(sw_mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction-level reference: one transaction occupies the cycles [t0, t0+LAT+1].
    bit          busy;
    int          t0, owner, last_grant;
    bit          own_we;
    logic [31:0] own_addr, own_wdata;
    logic [31:0] exp_rd [2];
    bit          acked [2];

    // Stimulus controls.
    int          mode;
    bit          kick [2], kick_we [2], drop_now [2];
    logic [31:0] kick_addr [2], kick_wdata [2];
    bit          rst_now, rand_rst_en, use_fixed, log_acks;
    logic [31:0] rd_fixed;
    int          en_seen, ack_seen [2];
    int          log_owner [$];
    int          log_cyc [$];

    function automatic int pick(input logic c, input logic d);
        if (c && d) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
            return DBG;
`else
            return (last_grant == CPU) ? DBG : CPU;
`endif
        end
        return c ? CPU : DBG;
    endfunction

    task automatic new_req(input int r);
        req[r]      = 1'b1;
        rq_we[r]    = 1'($urandom_range(0, 1));
        rq_addr[r]  = $urandom();
        rq_wdata[r] = $urandom();
    endtask

    task automatic step();
        logic ack_exp [2];
        logic en_exp;
        bit   inflight;
        @(posedge clk);
        #1;
        rst     = rst_now || (rand_rst_en && $urandom_range(0, 299) == 0);
        rst_now = 1'b0;
        for (int r = 0; r < 2; r++) begin
            inflight = busy && owner == r;
            if (drop_now[r]) begin
                req[r]      = 1'b0;
                drop_now[r] = 1'b0;
            end else if (kick[r]) begin
                req[r]      = 1'b1;
                rq_we[r]    = kick_we[r];
                rq_addr[r]  = kick_addr[r];
                rq_wdata[r] = kick_wdata[r];
                kick[r]     = 1'b0;
            end else if (mode == M_FLOOD) begin
                if (acked[r] || !req[r]) new_req(r);
            end else begin
                if (acked[r]) req[r] = 1'b0;
                if (mode == M_RANDOM) begin
                    if (req[r] && !inflight && $urandom_range(0, 15) == 0) req[r] = 1'b0;
                    else if (req[r] && inflight && $urandom_range(0, 7) == 0) req[r] = 1'b0;
                    else if (!req[r] && !inflight && $urandom_range(0, 2) == 0) new_req(r);
                end
            end
        end
        mem_rdata = use_fixed ? rd_fixed : $urandom();

        @(negedge clk);
        en_exp = busy && cyc == t0 + 1;
        check("mem_en", 32'(mem_en), 32'(en_exp));
        check("mem_we", 32'(mem_we), 32'(en_exp && own_we));
        if (en_exp) begin
            check("mem_addr", mem_addr, own_addr);
            if (own_we) check("mem_wdata", mem_wdata, own_wdata);
        end
        for (int r = 0; r < 2; r++) begin
            ack_exp[r] = busy && cyc == t0 + LAT + 1 && owner == r;
            check(r == CPU ? "cpu_ack" : "dbg_ack", 32'(ack_o[r]), 32'(ack_exp[r]));
            if (ack_exp[r] && !own_we) check(r == CPU ? "cpu_rdata" : "dbg_rdata", rdata_o[r], exp_rd[r]);
            if (ack_o[r]) begin
                ack_seen[r]++;
                if (log_acks) begin
                    log_owner.push_back(r);
                    log_cyc.push_back(cyc);
                end
            end
        end
        check("cpu_stall", 32'(cpu_stall), 32'(req[CPU] && !ack_exp[CPU]));
        if (mem_en) en_seen++;

        acked = '{1'b0, 1'b0};
        if (rst) begin
            busy       = 1'b0;
            last_grant = DBG;
            exp_rd     = '{32'h0, 32'h0};
        end else if (busy) begin
            if (cyc == t0 + LAT && !own_we) exp_rd[owner] = mem_rdata;
            if (cyc == t0 + LAT + 1) begin
                acked[owner] = 1'b1;
                busy         = 1'b0;
            end
        end else if (req[CPU] || req[DBG]) begin
            owner      = pick(req[CPU], req[DBG]);
            last_grant = owner;
            busy       = 1'b1;
            t0         = cyc;
            own_we     = rq_we[owner];
            own_addr   = rq_addr[owner];
            own_wdata  = rq_wdata[owner];
        end
        cyc++;
    endtask

    task automatic issue(input int r, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        kick[r]       = 1'b1;
        kick_we[r]    = we;
        kick_addr[r]  = addr;
        kick_wdata[r] = wdata;
    endtask

    initial begin
        int en0, ack0, ack_cpu0;
        int exp_owner;

        rst = 1'b1;
        req = '{1'b0, 1'b0};
        rq_we = '{1'b0, 1'b0};
        rq_addr = '{32'h0, 32'h0};
        rq_wdata = '{32'h0, 32'h0};
        mem_rdata = 32'h0;
        sw_req = '{1'b0, 1'b0};
        sw_addr = 32'h0;
        sw_mem_rdata = 32'h0;
        mode = M_QUIET;
        kick = '{1'b0, 1'b0};
        drop_now = '{1'b0, 1'b0};
        rst_now = 1'b0;
        rand_rst_en = 1'b0;
        use_fixed = 1'b0;
        log_acks = 1'b0;
        rd_fixed = 32'h0;
        en_seen = 0;
        ack_seen = '{0, 0};
        busy = 1'b0;
        t0 = 0;
        owner = CPU;
        last_grant = DBG;
        own_we = 1'b0;
        own_addr = 32'h0;
        own_wdata = 32'h0;
        exp_rd = '{32'h0, 32'h0};
        acked = '{1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_cpu_ack", 32'(ack_o[CPU]), 32'h0);
        check("rst_dbg_ack", 32'(ack_o[DBG]), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_rdata", rdata_o[CPU], 32'h0);
        check("rst_dbg_rdata", rdata_o[DBG], 32'h0);

        // CPU read of 0x10 returning 0xDEADBEEF.
        use_fixed = 1'b1;
        rd_fixed  = 32'hDEAD_BEEF;
        en0 = en_seen;
        issue(CPU, 1'b0, 32'h10, 32'h0);
        repeat (LAT + 4) step();
        check("cpu_read_en_count", 32'(en_seen - en0), 32'd1);
        check("cpu_read_rdata", rdata_o[CPU], 32'hDEAD_BEEF);

        // DBG write of 0x12345678 to 0x4.
        en0 = en_seen;
        ack_cpu0 = ack_seen[CPU];
        ack0 = ack_seen[DBG];
        issue(DBG, 1'b1, 32'h4, 32'h1234_5678);
        repeat (LAT + 4) step();
        check("dbg_write_en_count", 32'(en_seen - en0), 32'd1);
        check("dbg_write_ack_count", 32'(ack_seen[DBG] - ack0), 32'd1);
        check("dbg_write_no_cpu_ack", 32'(ack_seen[CPU] - ack_cpu0), 32'd0);
        use_fixed = 1'b0;

        // Both requesters asserting continuously.
        rst_now = 1'b1;
        step();
        mode = M_FLOOD;
        log_acks = 1'b1;
        repeat (4 * (LAT + 2) + 2) step();
        mode = M_QUIET;
        log_acks = 1'b0;
        drop_now = '{1'b1, 1'b1};
        repeat (LAT + 4) step();
        check("flood_ack_count", 32'(log_owner.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < log_owner.size(); i++) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
            exp_owner = DBG;
`else
            exp_owner = (i % 2 == 0) ? CPU : DBG;
`endif
            check("flood_grant_order", 32'(log_owner[i]), 32'(exp_owner));
            if (i > 0) check("flood_ack_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'(LAT + 2));
        end

        // Reset while a CPU read sits in WAIT, then a simultaneous request.
        rst_now = 1'b1;
        step();
        issue(CPU, 1'b0, 32'h80, 32'h0);
        step();
        step();
        rst_now = 1'b1;
        drop_now[CPU] = 1'b1;
        ack0 = ack_seen[CPU] + ack_seen[DBG];
        step();
        repeat (LAT + 3) step();
        check("reset_abort_no_ack", 32'(ack_seen[CPU] + ack_seen[DBG] - ack0), 32'd0);
        log_owner.delete();
        log_cyc.delete();
        log_acks = 1'b1;
        issue(CPU, 1'b0, $urandom(), 32'h0);
        issue(DBG, 1'b0, $urandom(), 32'h0);
        repeat (2 * (LAT + 2) + 2) step();
        log_acks = 1'b0;
        check("post_reset_ack_count", 32'(log_owner.size()), 32'd2);
`ifdef MEM_ARB_DBG_PRIORITY_EN
        exp_owner = DBG;
`else
        exp_owner = CPU;
`endif
        if (log_owner.size() > 0) check("post_reset_first_grant", 32'(log_owner[0]), 32'(exp_owner));

        // Randomized traffic with occasional resets.
        mode = M_RANDOM;
        rand_rst_en = 1'b1;
        repeat (3000) step();
        mode = M_QUIET;
        rand_rst_en = 1'b0;
        drop_now = '{1'b1, 1'b1};
        repeat (LAT + 6) step();

        // MEM_LAT=1 and MEM_LAT=15 sweeps: three reads each, bounded to 41 cycles per read.
        for (int tr = 0; tr < 3; tr++) begin
            int          en_cnt  [2];
            int          ack_cnt [2];
            int          ack_cyc [2];
            logic [31:0] got_rd  [2];
            int          sw_lat  [2];
            sw_lat  = '{1, 15};
            en_cnt  = '{0, 0};
            ack_cnt = '{0, 0};
            ack_cyc = '{-1, -1};
            got_rd  = '{32'h0, 32'h0};
            for (int c = 0; c <= 40; c++) begin
                @(posedge clk);
                #1;
                if (c == 0) begin
                    sw_req  = '{1'b1, 1'b1};
                    sw_addr = $urandom();
                end else begin
                    for (int r = 0; r < 2; r++) if (ack_cyc[r] >= 0) sw_req[r] = 1'b0;
                end
                sw_mem_rdata = 32'hC0DE_0000 + 32'(c);
                @(negedge clk);
                for (int r = 0; r < 2; r++) begin
                    if (sw_en[r]) begin
                        en_cnt[r]++;
                        check("sweep_mem_addr", sw_maddr[r], sw_addr);
                    end
                    if (sw_ack[r]) begin
                        ack_cnt[r]++;
                        if (ack_cyc[r] < 0) ack_cyc[r] = c;
                        got_rd[r] = sw_rdata[r];
                    end
                end
            end
            for (int r = 0; r < 2; r++) begin
                check(r == 0 ? "lat1_en_count" : "lat15_en_count", 32'(en_cnt[r]), 32'd1);
                check(r == 0 ? "lat1_ack_count" : "lat15_ack_count", 32'(ack_cnt[r]), 32'd1);
                check(r == 0 ? "lat1_ack_latency" : "lat15_ack_latency", 32'(ack_cyc[r]), 32'(sw_lat[r] + 1));
                check(r == 0 ? "lat1_rdata" : "lat15_rdata", got_rd[r], 32'hC0DE_0000 + 32'(sw_lat[r]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle core between two requesters: the CPU datapath (fetch, load, store) and a debug/program-loader port.
- Sits between the datapath memory interface and the memory macro, and owns all memory enables.
- Sequences each access as a fixed-latency transaction and returns a one-cycle acknowledge.
- Raises a stall to the control FSM while a CPU access is pending.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 2, memory read latency in cycles from o_mem_en to valid i_mem_rdata; legal range 1..15.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_cpu_req  input  1  CPU access request; held high until o_cpu_ack.
- i_cpu_we  input  1  CPU write enable; stable while i_cpu_req is high.
- i_cpu_addr  input  AW  CPU address; stable while i_cpu_req is high.
- i_cpu_wdata  input  DW  CPU write data.
- o_cpu_ack  output  1  one-cycle completion pulse.
- o_cpu_rdata  output  DW  read data; valid with o_cpu_ack, held until the next CPU ack.
- o_cpu_stall  output  1  i_cpu_req & ~o_cpu_ack (combinational).
- i_dbg_req  input  1  debug request; same rules as the CPU port.
- i_dbg_we  input  1  debug write enable.
- i_dbg_addr  input  AW  debug address.
- i_dbg_wdata  input  DW  debug write data.
- o_dbg_ack  output  1  one-cycle completion pulse.
- o_dbg_rdata  output  DW  debug read data; valid with o_dbg_ack, held until the next debug ack.
- o_mem_en  output  1  memory access strobe; exactly one cycle per transaction.
- o_mem_we  output  1  memory write enable; qualified by o_mem_en.
- o_mem_addr  output  AW  memory address; registered.
- o_mem_wdata  output  DW  memory write data; registered.
- i_mem_rdata  input  DW  memory read data.

Behaviour:
- Reset values:
  - State is IDLE.
  - o_cpu_ack, o_dbg_ack, o_mem_en and o_mem_we are 0.
  - o_mem_addr, o_mem_wdata, o_cpu_rdata and o_dbg_rdata are 0.
  - Latency counter is 0.
  - Last-grant pointer is DBG, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that is not the last grant (round-robin), then update the pointer.
  - On grant: register addr, wdata and we from the winner; go to ACCESS.
- ACCESS (1 cycle):
  - o_mem_en=1 and o_mem_we=granted we.
  - Load counter with MEM_LAT-1.
  - Go to WAIT, or directly to RESP-capture when MEM_LAT=1.
- WAIT:
  - o_mem_en=0.
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture i_mem_rdata into the granted requester's rdata register at that clock edge, then go to RESP. Writes also capture; the captured value is don't-care.
- RESP (1 cycle): assert the granted requester's ack only, then go to IDLE.
- Timing, with request seen in IDLE at cycle t:
  - o_mem_en is high in cycle t+1.
  - i_mem_rdata is sampled at the end of cycle t+MEM_LAT.
  - Ack is high in cycle t+MEM_LAT+1.
  - Throughput is one transaction per MEM_LAT+2 cycles.
- Requester rule: deassert req in the cycle after ack, or issue a new request. IDLE following RESP re-arbitrates normally.
- A request dropped before its grant is ignored.
- A request dropped after its grant still completes and its ack is still issued.
- The non-granted requester stays pending; no request is lost or reordered.
- Simultaneous continuous requests alternate CPU, DBG, CPU, ...
- Reset mid-transaction:
  - The transaction is aborted; no ack is generated.
  - o_mem_en and o_mem_we are 0 from the next cycle.
  - The pointer returns to DBG.
- o_mem_we is never high while o_mem_en is low.

Optional Feature:
- Macro: MEM_ARB_DBG_PRIORITY_EN.
- Defined:
  - Arbitration is fixed priority with debug winning ties, so the CPU can be frozen while the loader streams.
  - The round-robin pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- MEM_LAT=2; CPU read of addr 0x10, memory returns 0xDEADBEEF:
  - o_mem_en high exactly 1 cycle with o_mem_addr=0x10 and o_mem_we=0.
  - o_cpu_ack 3 cycles after the request cycle with o_cpu_rdata=0xDEADBEEF.
  - o_cpu_stall high until the ack.
- DBG write addr 0x4, data 0x12345678:
  - o_mem_we=1 together with o_mem_en, o_mem_wdata=0x12345678.
  - o_dbg_ack pulses and o_cpu_ack stays 0.
- Both requesters assert continuously for 4 transactions:
  - Grant order is CPU, DBG, CPU, DBG.
  - Acks are 4 cycles apart (MEM_LAT+2).
- With MEM_ARB_DBG_PRIORITY_EN, same stimulus: all 4 grants go to DBG and the CPU stays stalled.
- i_reset asserted during WAIT:
  - No ack is generated and o_mem_en=0 on the next cycle.
  - A subsequent simultaneous request is granted to the CPU first.
- MEM_LAT=1 and MEM_LAT=15 sweeps: ack latency equals MEM_LAT+1 cycles, with exactly one o_mem_en per transaction.
